// File: rtl/leg_mem_arb_pkg.sv
// leg_mem_arb_pkg: shared types for the memory port arbiter
package leg_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_stats.sv
// mem_arb_stats: saturating grant/conflict counters for the memory port arbiter
module mem_arb_stats (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_gnt,
  input  logic        i_d_gnt,
  input  logic        i_conflict,
  output logic [31:0] o_stat_i_grants,
  output logic [31:0] o_stat_d_grants,
  output logic [31:0] o_stat_conflicts
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_i_grants  <= '0;
      o_stat_d_grants  <= '0;
      o_stat_conflicts <= '0;
    end else begin
      if (i_i_gnt && !(&o_stat_i_grants)) o_stat_i_grants <= o_stat_i_grants + 32'd1;
      if (i_d_gnt && !(&o_stat_d_grants)) o_stat_d_grants <= o_stat_d_grants + 32'd1;
      if (i_conflict && !(&o_stat_conflicts)) o_stat_conflicts <= o_stat_conflicts + 32'd1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; MEM_ARB_STATS_EN adds grant/conflict counters
module mem_port_arbiter
  import leg_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_i_req,
  input  logic [ADDR_WIDTH-1:0] i_i_addr,
  output logic                  o_i_gnt,
  output logic                  o_i_stall,
  output logic                  o_i_rvalid,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [WORD_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [WORD_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [WORD_WIDTH-1:0] o_mem_wdata,
  input  logic [WORD_WIDTH-1:0] i_mem_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           o_stat_i_grants,
  output logic [31:0]           o_stat_d_grants,
  output logic [31:0]           o_stat_conflicts
`endif
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  arb_state_t    state, state_nxt;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          forced, i_gnt, d_gnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end
  // Grants are gated by reset so nothing reaches the memory while held in reset
  always_comb begin
    forced      = i_i_req && streak == SW'(MAX_D_STREAK);
    i_gnt       = i_rst_n & i_i_req & ~i_flush & (~i_d_req | forced);
    d_gnt       = i_rst_n & i_d_req & ~i_gnt;
    owner       = i_gnt ? OWN_I : OWN_D;
    state_nxt   = i_gnt ? I_RD : d_gnt ? (i_d_we ? D_WR : D_RD) : IDLE;
    o_i_gnt     = i_gnt;
    o_d_gnt     = d_gnt;
    o_i_stall   = i_rst_n & i_i_req & ~i_gnt;
    o_i_rvalid  = state == I_RD && !i_flush;
    o_d_rvalid  = state == D_RD;
    o_mem_addr  = (i_gnt | d_gnt) ? (owner == OWN_I ? i_i_addr : i_d_addr) : '0;
    o_mem_write = d_gnt & i_d_we;
    o_mem_wdata = (d_gnt & i_d_we) ? i_d_wdata : '0;
  end
  assign o_rdata = i_mem_data;
  // Streak counts D wins while I is waiting; any gap in I's request resets it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                        streak <= '0;
    else if (i_gnt || !i_i_req)                          streak <= '0;
    else if (d_gnt && streak != SW'(MAX_D_STREAK))       streak <= streak + 1'b1;
  end
`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_i_gnt         (i_gnt),
    .i_d_gnt         (d_gnt),
    .i_conflict      (i_rst_n & i_i_req & i_d_req),
    .o_stat_i_grants (o_stat_i_grants),
    .o_stat_d_grants (o_stat_d_grants),
    .o_stat_conflicts(o_stat_conflicts)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a word-addressed memory model
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_data = '0;
  logic        i_gnt, i_stall, i_rvalid, d_gnt, d_rvalid, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .MAX_D_STREAK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(i_gnt), .o_i_stall(i_stall), .o_i_rvalid(i_rvalid),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_rdata(rdata),
    .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata), .i_mem_data(mem_data)
  );

  initial for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 | k;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    mem_data <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_i;
    // reset with requests pending: everything quiet
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h44;
    #1;
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_stall", i_stall, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_mem_write", mem_write, 1'b0);
    // reset asserted while a fetch is in flight
    @(negedge clk); rst_n = 1'b1; d_req = 1'b0; #1;
    chk1("pre_i_gnt", i_gnt, 1'b1);
    chk("pre_addr", mem_addr, 32'h40);
    @(negedge clk); i_req = 1'b0; rst_n = 1'b0; #1;
    chk1("mid_rst_rvalid", i_rvalid, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk1("post_rst_rvalid", i_rvalid, 1'b0);
    // fetch-only stream
    @(negedge clk); i_req = 1'b1; i_addr = 32'h00; #1;
    chk1("f0_gnt", i_gnt, 1'b1);
    chk("f0_addr", mem_addr, 32'h00);
    @(negedge clk); i_addr = 32'h04; #1;
    chk1("f1_gnt", i_gnt, 1'b1);
    chk1("f1_rvalid", i_rvalid, 1'b1);
    chk("f1_rdata", rdata, 32'hA000_0000);
    @(negedge clk); i_addr = 32'h08; #1;
    chk1("f2_gnt", i_gnt, 1'b1);
    chk1("f2_rvalid", i_rvalid, 1'b1);
    chk("f2_rdata", rdata, 32'hA000_0001);
    @(negedge clk); i_req = 1'b0; #1;
    chk1("f3_rvalid", i_rvalid, 1'b1);
    chk("f3_rdata", rdata, 32'hA000_0002);
    chk1("f3_gnt", i_gnt, 1'b0);
    // conflict: D wins, I stalls
    @(negedge clk); i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
    chk1("cf_d_gnt", d_gnt, 1'b1);
    chk1("cf_i_gnt", i_gnt, 1'b0);
    chk1("cf_stall", i_stall, 1'b1);
    chk("cf_addr", mem_addr, 32'h100);
    @(negedge clk); d_req = 1'b0; #1;
    chk1("cf_d_rvalid", d_rvalid, 1'b1);
    chk("cf_rdata", rdata, 32'hA000_0040);
    chk1("cf_i_gnt2", i_gnt, 1'b1);
    chk1("cf_stall2", i_stall, 1'b0);
    @(negedge clk); i_req = 1'b0; #1;
    chk1("cf_i_rvalid", i_rvalid, 1'b1);
    chk("cf_i_rdata", rdata, 32'hA000_0004);
    // starvation guard: 4 D grants then one forced I grant, repeating
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h104;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_i = (c % 5) == 4;
      chk1("sv_i_gnt", i_gnt, exp_i);
      chk1("sv_d_gnt", d_gnt, !exp_i);
      chk1("sv_stall", i_stall, !exp_i);
      if (c > 0) begin
        chk1("sv_d_rvalid", d_rvalid, ((c - 1) % 5) != 4);
        chk1("sv_i_rvalid", i_rvalid, ((c - 1) % 5) == 4);
      end
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0; #1;
    chk1("sv_last_i_rvalid", i_rvalid, 1'b1);
    chk("idle_addr", mem_addr, 32'h0);
    chk("idle_wdata", mem_wdata, 32'h0);
    chk1("idle_write", mem_write, 1'b0);
    // write then read back
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; #1;
    chk1("wr_gnt", d_gnt, 1'b1);
    chk1("wr_write", mem_write, 1'b1);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); d_we = 1'b0; #1;
    chk1("wr_no_rvalid", d_rvalid, 1'b0);
    chk1("rd_write", mem_write, 1'b0);
    chk1("rd_gnt", d_gnt, 1'b1);
    @(negedge clk); d_req = 1'b0; #1;
    chk1("rd_rvalid", d_rvalid, 1'b1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    // flush kills in-flight fetch; concurrent D read proceeds
    @(negedge clk); i_req = 1'b1; i_addr = 32'h0C; #1;
    chk1("fl_n_gnt", i_gnt, 1'b1);
    @(negedge clk); flush = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h108; #1;
    chk1("fl_rvalid", i_rvalid, 1'b0);
    chk1("fl_i_gnt", i_gnt, 1'b0);
    chk1("fl_d_gnt", d_gnt, 1'b1);
    chk("fl_addr", mem_addr, 32'h108);
    @(negedge clk); flush = 1'b0; i_req = 1'b0; d_req = 1'b0; #1;
    chk1("fl_d_rvalid", d_rvalid, 1'b1);
    chk("fl_rdata", rdata, 32'hA000_0042);
    chk1("fl_i_rvalid2", i_rvalid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
